posl_tx_ctrl: RTL
=================

Name: posl_tx_ctrl

Overview:
Frame sequencer for the 8-bit parallel-to-serial shifter. Accepts parallel words on a valid/ready handshake and drives the shifter's load and shift strobes. Divides the clock down to a bit period and frames each word on a serial line as start bit, DATA_W data bits MSB first, then stop bit(s). Sits between a parallel word source and the shifter / serial pin.

Parameters:
DATA_W, 8, word width; must match the shifter width.
CLK_DIV, 4, clocks per serial bit period; must be ≥1.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
in_data  in  DATA_W  parallel word to transmit.
in_valid  in  1  in_data valid.
in_ready  out  1  controller accepts a word this cycle.
ser_in  in  1  current MSB from the shifter.
sh_load  out  1  one-cycle strobe: shifter loads sh_data.
sh_data  out  DATA_W  word to load; held from capture until the next capture.
sh_shift  out  1  one-cycle strobe: shifter shifts left by 1.
tx_line  out  1  framed serial output; idle-high.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse in the final stop cycle.

Behaviour:
- Reset (reset=0) is asynchronous, with immediate effect:
  - state=IDLE; div_cnt=0; bit_cnt=0; sh_data=0.
  - sh_load=0, sh_shift=0, frame_done=0, busy=0, in_ready=1, tx_line=1.
  - The shifter contents are not touched.
- Handshake:
  - A word is accepted on a rising edge with in_valid&&in_ready.
  - in_data is captured into sh_data and the state moves to START.
  - in_valid with in_ready=0 is ignored; the source holds the word.
- in_ready is 1 in IDLE and in the last cycle of the final STOP bit period; it is 0 otherwise.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 in every non-IDLE state and resets to 0 on each state change.
  - tick = (div_cnt==CLK_DIV-1).
  - With CLK_DIV=1, tick is asserted every cycle.
- FSM states and transitions:
  - IDLE: tx_line=1.
  - START: tx_line=0. sh_load=1 in the first START cycle only. On tick, go to DATA with bit_cnt=0.
  - DATA: tx_line=ser_in (combinational from the registered state).
    - On tick with bit_cnt<DATA_W-1: sh_shift=1 for that cycle and bit_cnt++.
    - On tick with bit_cnt==DATA_W-1: go to STOP; no shift is issued.
    - Exactly DATA_W-1 shifts are issued per frame.
  - STOP: tx_line=1 for STOP_BITS*CLK_DIV cycles.
    - frame_done=1 in the last cycle.
    - At the end, go to START if a word is accepted in that same cycle (back-to-back, no idle gap); otherwise go to IDLE.
- busy = (state!=IDLE).
- Frame length is (1+DATA_W+STOP_BITS)*CLK_DIV cycles.
- Latency: the first START cycle is the cycle after acceptance.
- sh_load and sh_shift are never asserted in the same cycle.
- A new frame after reset mid-frame starts cleanly from IDLE; no residual strobes.

Test Plan:
- DATA_W=8, CLK_DIV=4, STOP_BITS=1; accept 0xA5 at the cycle-0 edge:
  - tx_line=0 in cycles 1-4.
  - Then bits 1,0,1,0,0,1,0,1, each for 4 cycles (cycles 5-36).
  - Then tx_line=1 in cycles 37-40.
  - sh_load=1 in cycle 1 only; 7 sh_shift pulses at cycles 8, 12, …, 32.
  - frame_done=1 in cycle 40 only; busy=1 in cycles 1-40.
- Back-to-back 0xFF then 0x00 with in_valid held high:
  - The second word is accepted in cycle 40.
  - The START bit of 0x00 begins in cycle 41, with no idle cycle between frames.
- Reset pulse low during the 4th data bit of 0x5A:
  - tx_line=1, busy=0 and in_ready=1 immediately, with no strobes.
  - A following 0x3C frame is bit-exact.
- CLK_DIV=1, STOP_BITS=2; send 0x81:
  - tx_line sequence 0,1,0,0,0,0,0,0,1,1,1 over 11 cycles.
  - frame_done in the 11th cycle.
- in_data changes while busy and in_valid toggles:
  - No acceptance and no change to sh_data.
  - The frame in flight is unaffected.

Source files
------------

// File: rtl/posl_tx_ctrl.sv
// Frame sequencer for the parallel-to-serial shifter: start bit, DATA_W data bits MSB first, stop bit(s).
// Latency: first START cycle follows the accept edge; frame lasts (1+DATA_W+STOP_BITS)*CLK_DIV cycles.
// Backpressure: in_ready only in IDLE or the final stop cycle; a word offered while busy is held by the source.
module posl_tx_ctrl #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ser_in,
    output logic              sh_load,
    output logic [DATA_W-1:0] sh_data,
    output logic              sh_shift,
    output logic              tx_line,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [DIV_W-1:0]    w_div_nxt;
    // Counts data bits in DATA and stop bits in STOP; cleared on every state change.
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [DATA_W-1:0]   r_sh_data;
    logic                w_tick;
    logic                w_last_stop;
    logic                w_accept;

    assign w_tick      = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_last_stop = (r_state == ST_STOP) && w_tick && (r_bit_cnt == BIT_W'(STOP_BITS - 1));
    assign in_ready    = (r_state == ST_IDLE) || w_last_stop;
    assign w_accept    = in_valid && in_ready;
    assign sh_data     = r_sh_data;
    assign busy        = (r_state != ST_IDLE);
    assign frame_done  = w_last_stop;

    // State, divider and bit counters, plus the captured word handed to the shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sh_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            if (w_accept) begin
                r_sh_data <= in_data;
            end
        end
    end

    // Next-state, counter updates and per-state line/strobe outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        tx_line     = 1'b1;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_nxt = '0;
                w_bit_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx_line = 1'b0;
                // START lasts a whole bit period, so div_cnt==0 marks its first cycle.
                sh_load = (r_div_cnt == '0);
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            ST_DATA: begin
                tx_line = ser_in;
                if (w_tick) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                        // The last bit is already at the MSB; no shift is needed.
                        w_state_nxt = ST_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        sh_shift  = 1'b1;
                        w_bit_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            ST_STOP: begin
                tx_line = 1'b1;
                if (w_tick) begin
                    w_div_nxt = '0;
                    if (w_last_stop) begin
                        w_bit_nxt   = '0;
                        // Back-to-back frames skip IDLE entirely.
                        w_state_nxt = w_accept ? ST_START : ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

endmodule
